// File: rtl/branch_resolve.sv
// IF/ID register with branch condition and target resolution feeding the fetch redirect.
// Optional perf counters are built when BRANCH_PERF_CNT_EN is defined.
module branch_resolve (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] PC_curr,
   input  logic [15:0] PC_next,
   input  logic [15:0] PC_inst,
   input  logic [1:0]  prediction,
   input  logic [15:0] predicted_target,
   input  logic [2:0]  flags,
   input  logic [15:0] reg_target,
   output logic [3:0]  IF_ID_PC_curr,
   output logic [1:0]  IF_ID_prediction,
   output logic        actual_taken,
   output logic [15:0] actual_target,
   output logic        wen_BTB,
   output logic        wen_BHT,
   output logic        update_PC,
   output logic        IF_ID_valid,
   output logic [15:0] branch_count,
   output logic [15:0] mispredict_count
);

   typedef struct packed {
      logic        valid;
      logic [15:0] pc_curr;
      logic [15:0] pc_next;
      logic [15:0] inst;
      logic [1:0]  pred;
      logic [15:0] pred_tgt;
   } if_id_t;

   if_id_t      id_q;
   if_id_t      id_d;

   logic        is_branch;
   logic        is_br_reg;
   logic        cond_ok;
   logic        mispredicted;
   logic        target_miscomputed;
   logic [2:0]  ccc;
   logic        flag_z;
   logic        flag_v;
   logic        flag_n;
   logic [7:0]  cond_vec;
   logic [15:0] b_offset;
   logic [15:0] b_target;
   logic        unused_pc_hi;

   // Only the low PC bits leave this stage; the rest is kept for debug visibility
   assign unused_pc_hi = ^id_q.pc_curr[15:4];

   // Next IF/ID contents: hold on stall, bubble on redirect, else take fetch
   always_comb begin
      id_d = id_q;
      if (enable) begin
         if (update_PC) begin
            id_d = '0;
         end else begin
            id_d.valid    = 1'b1;
            id_d.pc_curr  = PC_curr;
            id_d.pc_next  = PC_next;
            id_d.inst     = PC_inst;
            id_d.pred     = prediction;
            id_d.pred_tgt = predicted_target;
         end
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_q <= '0;
      end else begin
         id_q <= id_d;
      end
   end

   assign flag_z = flags[2];
   assign flag_v = flags[1];
   assign flag_n = flags[0];
   assign ccc    = id_q.inst[11:9];

   // One bit per condition code, indexed by ccc
   assign cond_vec = {
      1'b1,
      flag_v,
      flag_n | flag_z,
      flag_z | (~flag_z & ~flag_n),
      flag_n,
      ~flag_z & ~flag_n,
      flag_z,
      ~flag_z
   };

   assign cond_ok   = cond_vec[ccc];
   assign is_branch = id_q.valid & (id_q.inst[15:13] == 3'b110);
   assign is_br_reg = id_q.inst[12];

   assign b_offset = {{6{id_q.inst[8]}}, id_q.inst[8:0], 1'b0};
   assign b_target = id_q.pc_next + b_offset;

   assign actual_taken = is_branch & cond_ok;

   // Resolved target; zero whenever the branch falls through
   always_comb begin
      actual_target = 16'h0000;
      if (actual_taken) begin
         if (is_br_reg) begin
            actual_target = reg_target;
         end else begin
            actual_target = b_target;
         end
      end
   end

   assign mispredicted       = id_q.pred[1] != actual_taken;
   assign target_miscomputed = id_q.pred_tgt != actual_target;

   assign wen_BHT   = enable & is_branch & mispredicted;
   assign wen_BTB   = enable & is_branch
                    & (actual_taken | target_miscomputed);
   assign update_PC = enable & actual_taken
                    & (mispredicted | target_miscomputed);

   assign IF_ID_PC_curr    = id_q.pc_curr[3:0];
   assign IF_ID_prediction = id_q.pred;
   assign IF_ID_valid      = id_q.valid;

`ifdef BRANCH_PERF_CNT_EN
   logic [15:0] br_cnt_q;
   logic [15:0] mp_cnt_q;

   // Saturating counts of resolved branches and redirects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt_q <= 16'h0000;
         mp_cnt_q <= 16'h0000;
      end else begin
         if (enable && is_branch && br_cnt_q != 16'hFFFF) begin
            br_cnt_q <= br_cnt_q + 16'd1;
         end
         if (update_PC && mp_cnt_q != 16'hFFFF) begin
            mp_cnt_q <= mp_cnt_q + 16'd1;
         end
      end
   end

   assign branch_count     = br_cnt_q;
   assign mispredict_count = mp_cnt_q;
`else
   assign branch_count     = 16'h0000;
   assign mispredict_count = 16'h0000;
`endif

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port enable, input, 1 bit: IF/ID advance; 0 means the pipeline is stalled.
REQ-004 SHALL have inputs PC_curr 16, PC_next 16, PC_inst 16, prediction 2 and predicted_target 16, all driven by the fetch stage.
REQ-005 SHALL have inputs flags 3 ({Z,V,N} from the flag register) and reg_target 16 (rs value for BR).
REQ-006 SHALL have outputs IF_ID_PC_curr 4, IF_ID_prediction 2, actual_taken 1, actual_target 16, wen_BTB 1, wen_BHT 1, update_PC 1, IF_ID_valid 1.
REQ-007 SHALL have outputs branch_count 16 and mispredict_count 16 (see Configuration).

Function
REQ-008 SHALL hold an IF/ID register: PC_curr, PC_next, PC_inst, prediction, predicted_target and valid.
REQ-009 On enable=1 the register SHALL load the fetch inputs with valid=1, unless update_PC=1 that cycle, in which case it loads valid=0 (bubble) and zeros the other fields.
REQ-010 On enable=0 the IF/ID register SHALL hold every field.
REQ-011 is_branch SHALL equal IF_ID_valid AND IF_ID_PC_inst[15:13]=3'b110 (B=1100, BR=1101).
REQ-012 Condition ccc=IF_ID_PC_inst[11:9] SHALL decode as follows: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-013 actual_taken SHALL equal is_branch AND the condition; it is 0 for non-branches.
REQ-014 For B, actual_target SHALL be IF_ID_PC_next + (sign-extended imm[8:0] << 1), modulo 2^16.
REQ-015 For BR, actual_target SHALL be reg_target.
REQ-016 When actual_taken=0, actual_target SHALL be 0.
REQ-017 mispredicted SHALL be IF_ID_prediction[1] != actual_taken.
REQ-018 target_miscomputed SHALL be IF_ID_predicted_target != actual_target.
REQ-019 wen_BHT SHALL be enable & is_branch & mispredicted.
REQ-020 wen_BTB SHALL be enable & is_branch & (actual_taken | target_miscomputed).
REQ-021 update_PC SHALL be enable & actual_taken & (mispredicted | target_miscomputed).
REQ-022 IF_ID_PC_curr SHALL be the IF/ID PC_curr[3:0]; IF_ID_prediction SHALL be the IF/ID prediction.
REQ-023 All outputs other than counters SHALL be combinational from IF/ID state and inputs, with zero-cycle latency.
REQ-024 If update_PC and enable=0 would coincide, no write enable SHALL assert; resolution retries when enable returns to 1.

Reset
REQ-025 rst=1 SHALL asynchronously clear all IF/ID fields to 0, including valid.
REQ-026 During reset, all outputs SHALL read 0, including counters.
REQ-027 Deasserting rst mid-stall SHALL leave valid=0 until the first enable=1 edge.

Configuration
REQ-028 Macro BRANCH_PERF_CNT_EN defined: branch_count SHALL increment on each edge where enable & is_branch.
REQ-029 With the macro defined, mispredict_count SHALL increment on each edge where update_PC=1.
REQ-030 Both counters SHALL saturate at 16'hFFFF.
REQ-031 Macro BRANCH_PERF_CNT_EN undefined: both counters SHALL be tied to 0 with no flops inferred.

Verification
REQ-032 Reset mid-run (rst=1 asynchronous pulse between edges) -> all outputs 0 immediately, with IF_ID_valid=0.
REQ-033 B ccc=001, Z=1, PC_next=0x0010, imm=0x1FE, prediction=2'b00 -> actual_taken=1, actual_target=0x000C, update_PC=1, wen_BHT=1, wen_BTB=1, next-cycle IF_ID_valid=0.
REQ-034 B ccc=000, Z=1, prediction=2'b10, predicted_target=0x0040 -> actual_taken=0, actual_target=0, wen_BHT=1, wen_BTB=1, update_PC=0.
REQ-035 BR ccc=111, reg_target=0x1234, prediction=2'b11, predicted_target=0x1234 -> actual_taken=1, update_PC=0, wen_BTB=1, wen_BHT=0.
REQ-036 Same as REQ-033 with enable=0 for 3 cycles -> no write enables and IF/ID held; on the enable=1 cycle the update_PC pulse is exactly 1 cycle.
REQ-037 With BRANCH_PERF_CNT_EN, 5 branches with 2 mispredictions -> branch_count=5, mispredict_count=2; without the macro both read 0.
